inter_packet_gap_monitor: RTL and testbench

// - Receive-side counterpart of the generator's inter-packet delay stage.
// - Sits on the OSNT monitor AXI-Stream path and measures the idle gap between consecutive packets, in axi_aclk cycles.
// - Stamps each measured gap into tuser of the packet's first beat.
// - Keeps last/min/max/count statistics for the AXI-Lite register block.

---
 rtl/inter_packet_gap_monitor_pkg.sv | 18 +
 rtl/axis_pipe_reg.sv | 59 +++++
 rtl/inter_packet_gap_monitor.sv | 166 ++++++++++++++++
 tb/tb_inter_packet_gap_monitor.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inter_packet_gap_monitor_pkg.sv
// Shared definitions for the inter-packet gap monitor. The default tuser gap
// field location is also used by the generator's inter-packet delay stage, so
// both ends of the link agree on where the gap lives.
package inter_packet_gap_monitor_pkg;

  // Default width of gap, statistic and counter values.
  localparam int unsigned GAP_WIDTH_DEFAULT = 32;

  // Default LSB of the tuser field that carries the measured gap.
  localparam int unsigned GAP_TUSER_OFFSET_DEFAULT = 32;

  // Packet framing state seen on the slave side.
  typedef enum logic [0:0] {
    StIdle,
    StInPkt
  } frame_state_e;

endpackage

// File: rtl/axis_pipe_reg.sv
// Generic one-stage AXI-Stream register slice (tdata/tstrb/tuser/tlast).
// Full throughput, one cycle latency, output held stable under backpressure.
module axis_pipe_reg #(
  parameter int unsigned DataWidth = 256,
  parameter int unsigned UserWidth = 128
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [DataWidth-1:0]   i_s_tdata,
  input  logic [DataWidth/8-1:0] i_s_tstrb,
  input  logic [UserWidth-1:0]   i_s_tuser,
  input  logic                   i_s_tlast,
  input  logic                   i_s_tvalid,
  output logic                   o_s_tready,
  output logic [DataWidth-1:0]   o_m_tdata,
  output logic [DataWidth/8-1:0] o_m_tstrb,
  output logic [UserWidth-1:0]   o_m_tuser,
  output logic                   o_m_tlast,
  output logic                   o_m_tvalid,
  input  logic                   i_m_tready
);

  logic                   r_valid;
  logic [DataWidth-1:0]   r_tdata;
  logic [DataWidth/8-1:0] r_tstrb;
  logic [UserWidth-1:0]   r_tuser;
  logic                   r_tlast;
  logic                   w_s_tready;

  // Slot can take a new beat when empty or when its content leaves this cycle.
  assign w_s_tready = !r_valid || i_m_tready;

  // Register slot: load on acceptance, empty when drained with nothing incoming.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_tdata <= '0;
      r_tstrb <= '0;
      r_tuser <= '0;
      r_tlast <= 1'b0;
    end else if (w_s_tready) begin
      r_valid <= i_s_tvalid;
      if (i_s_tvalid) begin
        r_tdata <= i_s_tdata;
        r_tstrb <= i_s_tstrb;
        r_tuser <= i_s_tuser;
        r_tlast <= i_s_tlast;
      end
    end
  end

  assign o_s_tready = w_s_tready;
  assign o_m_tvalid = r_valid;
  assign o_m_tdata  = r_tdata;
  assign o_m_tstrb  = r_tstrb;
  assign o_m_tuser  = r_tuser;
  assign o_m_tlast  = r_tlast;

endmodule

// File: rtl/inter_packet_gap_monitor.sv
// Measures the idle gap (in axi_aclk cycles) between consecutive packets on
// the monitor AXI-Stream path, stamps it into the first beat's tuser field and
// keeps last/min/max/count statistics for the register block.
module inter_packet_gap_monitor
  import inter_packet_gap_monitor_pkg::*;
#(
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_S_AXI_DATA_WIDTH   = GAP_WIDTH_DEFAULT,
  parameter int unsigned C_GAP_TUSER_OFFSET   = GAP_TUSER_OFFSET_DEFAULT
) (
  input  logic                              axi_aclk,
  input  logic                              axi_areset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  input  logic                              sw_rst,
  input  logic                              ipg_en,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     last_gap,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     min_gap,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     max_gap,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     gap_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     pkt_count
);

  localparam int unsigned     GapW        = C_S_AXI_DATA_WIDTH;
  localparam logic [GapW-1:0] GapOne      = {{(GapW-1){1'b0}}, 1'b1};
  localparam logic [GapW-1:0] MinGapReset = '1;

  // Handshake and framing
  logic                            w_s_tready;
  logic                            w_accept;
  logic                            w_accept_last;
  logic                            w_in_pkt;
  logic                            w_first;
  frame_state_e                    r_state;
  frame_state_e                    w_state_d;

  // Gap measurement
  logic [GapW-1:0]                 r_gap;
  logic [GapW-1:0]                 w_gap_d;
  logic                            r_armed;
  logic                            w_gap_valid;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] w_tuser_stamped;

  // Statistics
  logic [GapW-1:0]                 r_last_gap;
  logic [GapW-1:0]                 r_min_gap;
  logic [GapW-1:0]                 r_max_gap;
  logic [GapW-1:0]                 r_gap_count;
  logic [GapW-1:0]                 r_pkt_count;

  assign w_accept      = s_axis_tvalid && w_s_tready;
  assign w_accept_last = w_accept && s_axis_tlast;
  assign w_in_pkt      = (r_state == StInPkt);
  assign w_first       = w_accept && !w_in_pkt;
  // Only a first beat following an armed packet end yields a usable gap.
  assign w_gap_valid   = w_first && r_armed && ipg_en;

  // Framing next state: enter a packet on a non-last beat, leave on tlast.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_accept && !s_axis_tlast) w_state_d = StInPkt;
      StInPkt: if (w_accept_last) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Framing state register; sw_rst deliberately leaves framing alone.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) r_state <= StIdle;
    else            r_state <= w_state_d;
  end

  // Gap counter next value: restart at tlast, hold at 0 inside a packet,
  // otherwise count idle cycles and stick at all-ones.
  always_comb begin
    w_gap_d = r_gap;
    if (w_accept_last || w_in_pkt) begin
      w_gap_d = '0;
    end else if (!(&r_gap)) begin
      w_gap_d = r_gap + GapOne;
    end
  end

  // Gap counter register.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset || sw_rst) r_gap <= '0;
    else                      r_gap <= w_gap_d;
  end

  // Armed once a packet has ended while enabled; any clear or disable drops it.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset || sw_rst || !ipg_en) r_armed <= 1'b0;
    else if (w_accept_last)              r_armed <= 1'b1;
  end

  // Stamp the gap (or 0 when unarmed) into the first beat before the slice.
  always_comb begin
    w_tuser_stamped = s_axis_tuser;
    if (ipg_en && !w_in_pkt) begin
      w_tuser_stamped[C_GAP_TUSER_OFFSET +: GapW] = r_armed ? r_gap : '0;
    end
  end

  // Statistics; a clear takes priority over a same-cycle update.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset || sw_rst) begin
      r_last_gap  <= '0;
      r_min_gap   <= MinGapReset;
      r_max_gap   <= '0;
      r_gap_count <= '0;
      r_pkt_count <= '0;
    end else begin
      if (w_gap_valid) begin
        r_last_gap <= r_gap;
        if (r_gap < r_min_gap) r_min_gap <= r_gap;
        if (r_gap > r_max_gap) r_max_gap <= r_gap;
        if (!(&r_gap_count))   r_gap_count <= r_gap_count + GapOne;
      end
      if (w_accept_last && ipg_en && !(&r_pkt_count)) begin
        r_pkt_count <= r_pkt_count + GapOne;
      end
    end
  end

  axis_pipe_reg #(
    .DataWidth (C_S_AXIS_DATA_WIDTH),
    .UserWidth (C_S_AXIS_TUSER_WIDTH)
  ) u_pipe (
    .i_clk      (axi_aclk),
    .i_rst      (axi_areset),
    .i_s_tdata  (s_axis_tdata),
    .i_s_tstrb  (s_axis_tstrb),
    .i_s_tuser  (w_tuser_stamped),
    .i_s_tlast  (s_axis_tlast),
    .i_s_tvalid (s_axis_tvalid),
    .o_s_tready (w_s_tready),
    .o_m_tdata  (m_axis_tdata),
    .o_m_tstrb  (m_axis_tstrb),
    .o_m_tuser  (m_axis_tuser),
    .o_m_tlast  (m_axis_tlast),
    .o_m_tvalid (m_axis_tvalid),
    .i_m_tready (m_axis_tready)
  );

  assign s_axis_tready = w_s_tready;
  assign last_gap      = r_last_gap;
  assign min_gap       = r_min_gap;
  assign max_gap       = r_max_gap;
  assign gap_count     = r_gap_count;
  assign pkt_count     = r_pkt_count;

endmodule

// File: tb/tb_inter_packet_gap_monitor.sv
// Self-checking bench for inter_packet_gap_monitor: directed scenarios plus a
// randomized phase, checked against a transaction-level reference model that
// derives gaps from acceptance timestamps.
module tb_inter_packet_gap_monitor;

  typedef struct packed {
    logic [255:0] data;
    logic [31:0]  strb;
    logic [127:0] user;
    logic         last;
  } beat_t;

  logic         axi_aclk;
  logic         axi_areset;
  logic [255:0] s_axis_tdata;
  logic [31:0]  s_axis_tstrb;
  logic [127:0] s_axis_tuser;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         s_axis_tlast;
  logic [255:0] m_axis_tdata;
  logic [31:0]  m_axis_tstrb;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
  logic         sw_rst;
  logic         ipg_en;
  logic [31:0]  last_gap;
  logic [31:0]  min_gap;
  logic [31:0]  max_gap;
  logic [31:0]  gap_count;
  logic [31:0]  pkt_count;

  inter_packet_gap_monitor dut (
    .axi_aclk      (axi_aclk),
    .axi_areset    (axi_areset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tstrb  (s_axis_tstrb),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .sw_rst        (sw_rst),
    .ipg_en        (ipg_en),
    .last_gap      (last_gap),
    .min_gap       (min_gap),
    .max_gap       (max_gap),
    .gap_count     (gap_count),
    .pkt_count     (pkt_count)
  );

  initial axi_aclk = 1'b0;
  always #5 axi_aclk = ~axi_aclk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  beat_t       exp_q[$];       // beat expected on the master side
  bit          m_in_pkt;
  bit          m_armed;
  int          cyc;
  int          m_tlast_cyc;    // cycle index of the latest accepted tlast
  logic [31:0] m_last, m_min, m_max, m_gcnt, m_pcnt;

  // Stimulus controls
  bit          mrdy_q[$];      // scheduled m_axis_tready values, then default
  bit          rand_bp;
  bit          preset_field;
  logic [31:0] preset_val;
  beat_t       idle_b;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear_stats();
    m_last = '0;
    m_min  = '1;
    m_max  = '0;
    m_gcnt = '0;
    m_pcnt = '0;
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model.
  task automatic cycle(input bit tv, input beat_t b, output bit acc);
    bit          mr;
    bit          exp_rdy;
    bit          first;
    bit          upd;
    beat_t       sb;
    logic [31:0] gap;
    if (mrdy_q.size() > 0) mr = mrdy_q.pop_front();
    else if (rand_bp)      mr = ($urandom_range(3) != 0);
    else                   mr = 1'b1;
    s_axis_tvalid = tv;
    s_axis_tdata  = b.data;
    s_axis_tstrb  = b.strb;
    s_axis_tuser  = b.user;
    s_axis_tlast  = b.last;
    m_axis_tready = mr;
    @(negedge axi_aclk);
    exp_rdy = (exp_q.size() == 0) || mr;
    chk("s_tready", 256'(s_axis_tready), 256'(exp_rdy));
    chk("m_tvalid", 256'(m_axis_tvalid), 256'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("m_tdata", m_axis_tdata, exp_q[0].data);
      chk("m_tstrb", 256'(m_axis_tstrb), 256'(exp_q[0].strb));
      chk("m_tuser", 256'(m_axis_tuser), 256'(exp_q[0].user));
      chk("m_tlast", 256'(m_axis_tlast), 256'(exp_q[0].last));
    end
    chk("last_gap", 256'(last_gap), 256'(m_last));
    chk("min_gap", 256'(min_gap), 256'(m_min));
    chk("max_gap", 256'(max_gap), 256'(m_max));
    chk("gap_count", 256'(gap_count), 256'(m_gcnt));
    chk("pkt_count", 256'(pkt_count), 256'(m_pcnt));
    acc = 1'b0;
    if (axi_areset) begin
      exp_q.delete();
      m_in_pkt = 1'b0;
      m_armed  = 1'b0;
      model_clear_stats();
    end else begin
      acc = tv && exp_rdy;
      upd = 1'b0;
      gap = 32'(cyc - m_tlast_cyc - 1);
      if (exp_q.size() != 0 && mr) void'(exp_q.pop_front());
      if (acc) begin
        sb    = b;
        first = !m_in_pkt;
        if (first && ipg_en) sb.user[63:32] = m_armed ? gap : 32'd0;
        exp_q.push_back(sb);
        upd = first && m_armed && ipg_en;
      end
      if (sw_rst) begin
        model_clear_stats();
      end else begin
        if (upd) begin
          m_last = gap;
          if (gap < m_min) m_min = gap;
          if (gap > m_max) m_max = gap;
          if (m_gcnt != '1) m_gcnt = m_gcnt + 32'd1;
        end
        if (acc && b.last && ipg_en && m_pcnt != '1) m_pcnt = m_pcnt + 32'd1;
      end
      if (sw_rst || !ipg_en)  m_armed = 1'b0;
      else if (acc && b.last) m_armed = 1'b1;
      if (acc) begin
        m_in_pkt = !b.last;
        if (b.last) m_tlast_cyc = cyc;
      end
    end
    cyc++;
    @(posedge axi_aclk);
    #1;
  endtask

  // Idle cycles, then an n-beat packet; sw_rst held from beat sw_from to the end.
  task automatic send_pkt(input int n, input int idle, input int sw_from);
    beat_t b;
    bit    acc;
    int    tries;
    for (int i = 0; i < idle; i++) cycle(1'b0, idle_b, acc);
    for (int i = 0; i < n; i++) begin
      b.data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      b.strb = $urandom;
      b.user = {$urandom, $urandom, $urandom, $urandom};
      if (preset_field) b.user[63:32] = preset_val;
      b.last = (i == n - 1);
      if (sw_from >= 0 && i >= sw_from) sw_rst = 1'b1;
      tries = 0;
      acc   = 1'b0;
      while (!acc && tries < 64) begin
        cycle(1'b1, b, acc);
        tries++;
      end
      if (!acc) chk("accept_timeout", 256'(acc), 256'(1'b1));
    end
    sw_rst = 1'b0;
  endtask

  task automatic chk_stats(input string tag, input logic [31:0] l, input logic [31:0] mn,
                           input logic [31:0] mx, input logic [31:0] gc, input logic [31:0] pc);
    chk({tag, "_last"}, 256'(last_gap), 256'(l));
    chk({tag, "_min"}, 256'(min_gap), 256'(mn));
    chk({tag, "_max"}, 256'(max_gap), 256'(mx));
    chk({tag, "_gcnt"}, 256'(gap_count), 256'(gc));
    chk({tag, "_pcnt"}, 256'(pkt_count), 256'(pc));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    bit acc;
    idle_b        = '0;
    rand_bp       = 1'b0;
    preset_field  = 1'b0;
    preset_val    = 32'hDEADBEEF;
    axi_areset    = 1'b1;
    sw_rst        = 1'b0;
    ipg_en        = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tstrb  = '0;
    s_axis_tuser  = '0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge axi_aclk);
    #1;
    axi_areset  = 1'b0;
    m_in_pkt    = 1'b0;
    m_armed     = 1'b0;
    cyc         = 0;
    m_tlast_cyc = 0;
    model_clear_stats();

    // Reset state
    chk("rst_m_tvalid", 256'(m_axis_tvalid), 256'(1'b0));
    chk("rst_m_tdata", m_axis_tdata, 256'(0));
    chk("rst_m_tuser", 256'(m_axis_tuser), 256'(0));
    chk("rst_m_tlast", 256'(m_axis_tlast), 256'(1'b0));
    chk("rst_s_tready", 256'(s_axis_tready), 256'(1'b1));
    chk_stats("rst", 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0);

    // Two back-to-back 3-beat packets
    send_pkt(3, 0, -1);
    send_pkt(3, 0, -1);
    chk_stats("b2b", 32'd0, 32'd0, 32'd0, 32'd1, 32'd2);

    // 10 idle cycles then a single-beat packet
    send_pkt(1, 10, -1);
    chk_stats("idle10", 32'd10, 32'd0, 32'd10, 32'd2, 32'd3);

    // Clear, arm, then gaps 5, 2, 9
    sw_rst = 1'b1;
    cycle(1'b0, idle_b, acc);
    sw_rst = 1'b0;
    chk_stats("swclr", 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0);
    send_pkt(2, 3, -1);
    send_pkt(2, 5, -1);
    send_pkt(1, 2, -1);
    send_pkt(3, 9, -1);
    chk_stats("gaps", 32'd9, 32'd2, 32'd9, 32'd3, 32'd4);

    // Downstream stall mid-packet, then a stall ahead of the next first beat
    mrdy_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    send_pkt(6, 0, -1);
    mrdy_q = '{1'b0, 1'b0, 1'b0};
    send_pkt(2, 0, -1);
    chk("stall_gap", 256'(last_gap), 256'(32'd3));

    // sw_rst held from mid-packet through its tlast
    send_pkt(4, 2, 1);
    chk_stats("swmid", 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0);
    send_pkt(2, 4, -1);
    chk_stats("swnext", 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd1);

    // Disabled: field passes unchanged, statistics frozen
    ipg_en       = 1'b0;
    preset_field = 1'b1;
    send_pkt(3, 2, -1);
    send_pkt(1, 3, -1);
    chk_stats("dis", 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd1);
    ipg_en = 1'b1;
    send_pkt(2, 2, -1);
    chk_stats("reen", 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd2);
    preset_field = 1'b0;
    send_pkt(2, 6, -1);
    chk_stats("reen2", 32'd6, 32'd6, 32'd6, 32'd1, 32'd3);

    // Randomized traffic, backpressure and enable toggling
    rand_bp = 1'b1;
    for (int p = 0; p < 30; p++) begin
      ipg_en = ($urandom_range(7) != 0);
      send_pkt(int'($urandom_range(5, 1)), int'($urandom_range(6)), -1);
    end
    rand_bp = 1'b0;
    ipg_en  = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b0, idle_b, acc);

    // Reset in the middle of a packet
    begin
      beat_t b;
      for (int i = 0; i < 2; i++) begin
        b.data = {8{$urandom}};
        b.strb = $urandom;
        b.user = {4{$urandom}};
        b.last = 1'b0;
        cycle(1'b1, b, acc);
      end
    end
    axi_areset = 1'b1;
    cycle(1'b0, idle_b, acc);
    axi_areset = 1'b0;
    chk("midrst_tvalid", 256'(m_axis_tvalid), 256'(1'b0));
    chk_stats("midrst", 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0);
    send_pkt(2, 1, -1);
    send_pkt(1, 4, -1);
    chk_stats("postrst", 32'd4, 32'd4, 32'd4, 32'd1, 32'd2);
    for (int i = 0; i < 3; i++) cycle(1'b0, idle_b, acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
